// File: rtl/chia_ena_param.sv
// chia_ena_param: prescaled 1 kHz base tick and phase-aligned enable pulses
// for the timing tree. It provides fixed rates, a switch-selected debounce
// rate and a runtime-programmable channel.
module chia_ena_param #(
    parameter int unsigned PRESCALE = 50_000,
    parameter int unsigned DIV_W    = 16
) (
    input  logic             ckht,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       sw,
    input  logic             div_ld,
    input  logic [DIV_W-1:0] div_val,
    output logic             ena1khz,
    output logic             ena100hz,
    output logic             ena50hz,
    output logic             ena20hz,
    output logic             ena5hz,
    output logic             ena2hz,
    output logic             ena1hz,
    output logic             ena_db,
    output logic             ena_prog
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned N_DIV = 6;

    // Tick divisors, fastest first; index 5 is the 1 Hz boundary.
    function automatic int unsigned div_of(input int unsigned idx);
        case (idx)
            0:       div_of = 10;
            1:       div_of = 20;
            2:       div_of = 50;
            3:       div_of = 200;
            4:       div_of = 500;
            default: div_of = 1000;
        endcase
    endfunction

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic [N_DIV-1:0] w_hit;
    logic [1:0]       r_sel;
    logic             w_db;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pcnt;
    logic             w_pdone;
    logic             w_prog;

    // Prescaler: free-running modulo PRESCALE, frozen while run is low.
    always_ff @(posedge ckht) begin
        if (rst) begin
            r_pre <= '0;
        end else if (run) begin
            r_pre <= (r_pre == PRE_W'(PRESCALE - 1)) ? '0 : r_pre + PRE_W'(1);
        end
    end

    assign w_tick = run && (r_pre == PRE_W'(PRESCALE - 1));

    // One tick counter per derived rate; a hit is the tick that wraps it.
    for (genvar gi = 0; gi < N_DIV; gi++) begin : g_div
        localparam int unsigned D = div_of(gi);
        logic [CNT_W-1:0] r_cnt;

        // Count base ticks modulo D.
        always_ff @(posedge ckht) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= (r_cnt == CNT_W'(D - 1)) ? '0 : r_cnt + CNT_W'(1);
            end
        end

        assign w_hit[gi] = w_tick && (r_cnt == CNT_W'(D - 1));
    end

    // Debounce select only changes on a 1 Hz boundary, so no pulse is cut short.
    always_ff @(posedge ckht) begin
        if (rst || w_hit[5]) begin
            r_sel <= sw;
        end
    end

    // Mux uses the pre-update select, so the boundary pulse is always emitted.
    always_comb begin
        w_db = 1'b0;
        case (r_sel)
            2'b00:   w_db = w_hit[5];
            2'b01:   w_db = w_hit[2];
            2'b10:   w_db = w_hit[1];
            default: w_db = w_hit[0];
        endcase
    end

    assign w_pdone = w_tick && (r_div != '0) && (r_pcnt == r_div - DIV_W'(1));
    assign w_prog  = w_pdone && !div_ld;

    // Programmable channel: a load wins over a coincident tick.
    always_ff @(posedge ckht) begin
        if (rst) begin
            r_div  <= '0;
            r_pcnt <= '0;
        end else if (div_ld) begin
            r_div  <= div_val;
            r_pcnt <= '0;
        end else if (w_tick && (r_div != '0)) begin
            r_pcnt <= w_pdone ? '0 : r_pcnt + DIV_W'(1);
        end
    end

    // Output registers: one-cycle pulses, one cycle after the tick.
    always_ff @(posedge ckht) begin
        if (rst) begin
            ena1khz  <= 1'b0;
            ena100hz <= 1'b0;
            ena50hz  <= 1'b0;
            ena20hz  <= 1'b0;
            ena5hz   <= 1'b0;
            ena2hz   <= 1'b0;
            ena1hz   <= 1'b0;
            ena_db   <= 1'b0;
            ena_prog <= 1'b0;
        end else begin
            ena1khz  <= w_tick;
            ena100hz <= w_hit[0];
            ena50hz  <= w_hit[1];
            ena20hz  <= w_hit[2];
            ena5hz   <= w_hit[3];
            ena2hz   <= w_hit[4];
            ena1hz   <= w_hit[5];
            ena_db   <= w_db;
            ena_prog <= w_prog;
        end
    end

endmodule
